// File: rtl/qpsk_pkg.sv
// qpsk_pkg: constants and bit/symbol mapping convention shared with the transmit mapper
package qpsk_pkg;
    localparam int QPSK_DW = 16;
    localparam int QPSK_FRAC = 7;
    localparam logic signed [15:0] QPSK_AMP_POS = 16'sd90;
    localparam logic signed [15:0] QPSK_AMP_NEG = -16'sd90;
    localparam logic QPSK_BIT_POS = 1'b0;
    function automatic logic qpsk_decide(input logic neg);
        return neg ? ~QPSK_BIT_POS : QPSK_BIT_POS;
    endfunction
endpackage

// File: rtl/qpsk_ber_counter.sv
// qpsk_ber_counter: windowed bit-error accumulator with saturating error count and clear
module qpsk_ber_counter #(
    parameter int CNT_W = 32,
    parameter int BER_WIN_BITS = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [1:0]       nerr,
    input  logic             clr,
    output logic [CNT_W-1:0] ber_err,
    output logic             ber_done
);
    localparam int BW = $clog2(BER_WIN_BITS + 1);
    logic [CNT_W-1:0] err_acc, err_nxt;
    logic [CNT_W:0]   err_sum;
    logic [BW-1:0]    bit_acc, bit_nxt;
    logic             win_end;
    // next accumulator values including the symbol currently being decided
    always_comb begin
        err_sum = {1'b0, err_acc} + (CNT_W+1)'(nerr);
        err_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        bit_nxt = bit_acc + BW'(2);
        win_end = valid && bit_nxt == BW'(BER_WIN_BITS);
    end
    // clear wins over window completion; completion latches the count and restarts
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_acc  <= '0;
            bit_acc  <= '0;
            ber_err  <= '0;
            ber_done <= 1'b0;
        end else begin
            ber_done <= win_end;
            if (win_end) begin
                ber_err <= err_nxt;
                err_acc <= '0;
                bit_acc <= '0;
            end else if (valid) begin
                err_acc <= err_nxt;
                bit_acc <= bit_nxt;
            end
        end
    end
endmodule

// File: rtl/qpsk_demapper.sv
// qpsk_demapper: 2-stage hard-decision QPSK demapper with saturated decision error; BER counter under QPSK_DEMAP_BER_EN
module qpsk_demapper
    import qpsk_pkg::*;
#(
    parameter int DW = QPSK_DW,
    parameter int QPSK_AMP = int'(QPSK_AMP_POS),
    parameter int CNT_W = 32,
    parameter int BER_WIN_BITS = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_I,
    input  logic [DW-1:0]    in_Q,
    input  logic             ref_bit_I,
    input  logic             ref_bit_Q,
    input  logic             ber_clr,
    output logic             out_valid,
    output logic             bit_I,
    output logic             bit_Q,
    output logic [DW-1:0]    dec_I,
    output logic [DW-1:0]    dec_Q,
    output logic [DW-1:0]    err_I,
    output logic [DW-1:0]    err_Q,
    output logic [CNT_W-1:0] ber_err,
    output logic             ber_done
);
    localparam logic [DW-1:0] AMP_P = DW'(QPSK_AMP);
    localparam logic [DW-1:0] AMP_N = -AMP_P;
    function automatic logic [DW-1:0] sat(input logic [DW:0] e);
        return (e[DW] ^ e[DW-1]) ? {e[DW], {(DW-1){~e[DW]}}} : e[DW-1:0];
    endfunction
    logic          v1, b_i1, b_q1;
    logic [DW-1:0] i1, q1, dec_i2, dec_q2;
    // stage 1: capture the sample and take the sign decision
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            i1   <= '0;
            q1   <= '0;
            b_i1 <= 1'b0;
            b_q1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                i1   <= in_I;
                q1   <= in_Q;
                b_i1 <= qpsk_decide(in_I[DW-1]);
                b_q1 <= qpsk_decide(in_Q[DW-1]);
            end
        end
    end
    // map decided bits back to symbol amplitudes
    always_comb begin
        dec_i2 = (b_i1 == QPSK_BIT_POS) ? AMP_P : AMP_N;
        dec_q2 = (b_q1 == QPSK_BIT_POS) ? AMP_P : AMP_N;
    end
    // stage 2: register decisions and the saturated error decision - sample
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bit_I     <= 1'b0;
            bit_Q     <= 1'b0;
            dec_I     <= '0;
            dec_Q     <= '0;
            err_I     <= '0;
            err_Q     <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                bit_I <= b_i1;
                bit_Q <= b_q1;
                dec_I <= dec_i2;
                dec_Q <= dec_q2;
                err_I <= sat({dec_i2[DW-1], dec_i2} - {i1[DW-1], i1});
                err_Q <= sat({dec_q2[DW-1], dec_q2} - {q1[DW-1], q1});
            end
        end
    end
`ifdef QPSK_DEMAP_BER_EN
    logic ri1, rq1;
    // reference bits travel alongside the sample so they meet their decision
    always_ff @(posedge clk) begin
        if (rst) begin
            ri1 <= 1'b0;
            rq1 <= 1'b0;
        end else if (in_valid) begin
            ri1 <= ref_bit_I;
            rq1 <= ref_bit_Q;
        end
    end
    qpsk_ber_counter #(.CNT_W(CNT_W), .BER_WIN_BITS(BER_WIN_BITS)) u_ber (
        .clk      (clk),
        .rst      (rst),
        .valid    (v1),
        .nerr     ({1'b0, b_i1 ^ ri1} + {1'b0, b_q1 ^ rq1}),
        .clr      (ber_clr),
        .ber_err  (ber_err),
        .ber_done (ber_done)
    );
`else
    localparam int win_bits_unused = BER_WIN_BITS;
    logic ber_unused;
    assign ber_unused = ^{ref_bit_I, ref_bit_Q, ber_clr};
    assign ber_err = '0;
    assign ber_done = 1'b0;
`endif
endmodule

// File: tb/tb_qpsk_demapper.sv
// tb_qpsk_demapper: scoreboard bench for qpsk_demapper; BER expectations follow QPSK_DEMAP_BER_EN
module tb_qpsk_demapper;
`ifdef QPSK_DEMAP_BER_EN
    localparam bit BER_EN = 1'b1;
`else
    localparam bit BER_EN = 1'b0;
`endif
    localparam int WIN = 8;
    typedef struct {
        logic bi, bq;
        logic [15:0] di, dq, ei, eq;
        logic done;
        logic [31:0] ber;
    } exp_t;
    logic clk = 0, rst = 1, in_valid = 0, ref_bit_I = 0, ref_bit_Q = 0, ber_clr = 0;
    logic [15:0] in_I = 0, in_Q = 0;
    logic out_valid, bit_I, bit_Q, ber_done;
    logic [15:0] dec_I, dec_Q, err_I, err_Q;
    logic [31:0] ber_err;
    exp_t q[$];
    exp_t last;
    bit have_last = 0;
    int n_cmp = 0, n_fail = 0, m_err = 0, m_bits = 0;
    always #5 clk = ~clk;
    qpsk_demapper #(.BER_WIN_BITS(WIN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_I(in_I), .in_Q(in_Q),
        .ref_bit_I(ref_bit_I), .ref_bit_Q(ref_bit_Q), .ber_clr(ber_clr),
        .out_valid(out_valid), .bit_I(bit_I), .bit_Q(bit_Q), .dec_I(dec_I), .dec_Q(dec_Q),
        .err_I(err_I), .err_Q(err_Q), .ber_err(ber_err), .ber_done(ber_done)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic send(input int i, input int qv, input logic ri, input logic rq,
                        input logic bi, input logic bq, input int di, input int dq,
                        input int ei, input int eq, input bit clr_hit);
        exp_t e;
        e.bi = bi; e.bq = bq;
        e.di = 16'(di); e.dq = 16'(dq); e.ei = 16'(ei); e.eq = 16'(eq);
        e.done = 0; e.ber = 0;
        if (BER_EN) begin
            m_err += int'(bi != ri) + int'(bq != rq);
            m_bits += 2;
            if (clr_hit) begin
                m_err = 0; m_bits = 0;
            end else if (m_bits == WIN) begin
                e.done = 1; e.ber = 32'(m_err);
                m_err = 0; m_bits = 0;
            end
        end
        q.push_back(e);
        in_valid = 1; in_I = 16'(i); in_Q = 16'(qv); ref_bit_I = ri; ref_bit_Q = rq;
        @(posedge clk); #1;
        in_valid = 0;
    endtask
    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".bits"}, {30'd0, bit_I, bit_Q}, 0);
        chk({tag, ".dec"}, {dec_I, dec_Q}, 0);
        chk({tag, ".err"}, {err_I, err_Q}, 0);
        chk({tag, ".ber"}, {31'd0, ber_done} | ber_err, 0);
    endtask
    // monitor: pop expected entry on every out_valid, check hold and ber_done during bubbles
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("bit_I", 32'(bit_I), 32'(e.bi));
                chk("bit_Q", 32'(bit_Q), 32'(e.bq));
                chk("dec_I", 32'(dec_I), 32'(e.di));
                chk("dec_Q", 32'(dec_Q), 32'(e.dq));
                chk("err_I", 32'(err_I), 32'(e.ei));
                chk("err_Q", 32'(err_Q), 32'(e.eq));
                chk("ber_done", 32'(ber_done), 32'(e.done));
                if (!BER_EN || e.done) chk("ber_err", ber_err, e.ber);
                last = e;
                have_last = 1;
            end
        end else begin
            chk("ber_done_idle", 32'(ber_done), 0);
            if (have_last) begin
                chk("hold_bits", {30'd0, bit_I, bit_Q}, {30'd0, last.bi, last.bq});
                chk("hold_dec", {dec_I, dec_Q}, {last.di, last.dq});
                chk("hold_err", {err_I, err_Q}, {last.ei, last.eq});
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 0;
        send(90, -90, 0, 1, 0, 1, 90, -90, 0, 0, 0);
        send(0, -1, 0, 1, 0, 1, 90, -90, 90, -89, 0);
        send(-32768, 32767, 1, 0, 1, 0, -90, 90, 32678, -32677, 0);
        send(-5, 7, 1, 0, 1, 0, -90, 90, -85, 83, 0);
        idle(1);
        send(100, -200, 0, 1, 0, 1, 90, -90, -10, 110, 0);
        send(-1, 0, 1, 0, 1, 0, -90, 90, -89, 90, 0);
        rst = 1;
        @(posedge clk); #1;
        q.delete();
        have_last = 0; m_err = 0; m_bits = 0;
        rst = 0;
        repeat (3) begin @(negedge clk); chk_zero("flush"); end
        @(posedge clk); #1;
        send(200, 200, 0, 0, 0, 0, 90, 90, -110, -110, 0);
        send(-300, 50, 0, 0, 1, 0, -90, 90, 210, 40, 0);
        send(45, -45, 0, 1, 0, 1, 90, -90, 45, -45, 0);
        send(-128, -7, 0, 0, 1, 1, -90, -90, 38, -83, 0);
        send(200, 200, 0, 0, 0, 0, 90, 90, -110, -110, 0);
        send(-300, 50, 1, 0, 1, 0, -90, 90, 210, 40, 0);
        send(45, -45, 0, 1, 0, 1, 90, -90, 45, -45, 0);
        send(-128, -7, 1, 1, 1, 1, -90, -90, 38, -83, 0);
        idle(2);
        send(200, 200, 1, 0, 0, 0, 90, 90, -110, -110, 0);
        send(-300, 50, 1, 0, 1, 0, -90, 90, 210, 40, 0);
        send(45, -45, 0, 1, 0, 1, 90, -90, 45, -45, 0);
        send(-128, -7, 1, 1, 1, 1, -90, -90, 38, -83, 0);
        send(200, 200, 1, 1, 0, 0, 90, 90, -110, -110, 0);
        send(-300, 50, 0, 1, 1, 0, -90, 90, 210, 40, 0);
        send(45, -45, 1, 0, 0, 1, 90, -90, 45, -45, 0);
        send(-128, -7, 0, 0, 1, 1, -90, -90, 38, -83, 1);
        ber_clr = 1;
        @(posedge clk); #1;
        ber_clr = 0;
        @(negedge clk);
        chk("ber_err_after_clr", ber_err, 0);
        @(posedge clk); #1;
        send(200, 200, 0, 0, 0, 0, 90, 90, -110, -110, 0);
        send(-300, 50, 1, 0, 1, 0, -90, 90, 210, 40, 0);
        send(45, -45, 1, 1, 0, 1, 90, -90, 45, -45, 0);
        send(-128, -7, 1, 1, 1, 1, -90, -90, 38, -83, 0);
        idle(5);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
